// File: rtl/ctrl_mdio_sched_if.sv
// CPU request port and MDIO master command/readback bus of the MDIO scheduler.
// slave is the scheduler side, master the CPU/MDIO-master side.
interface ctrl_mdio_sched_if;
    logic        cpu_req;
    logic [31:0] cpu_cmd;
    logic        cpu_busy;
    logic        cpu_done;
    logic [15:0] cpu_rdata;
    logic        cpu_err;
    logic        mdio_wr;
    logic [31:0] mdio_data_wr;
    logic [31:0] mdio_data_rd;

    modport slave (
        input  cpu_req, cpu_cmd, mdio_data_rd,
        output cpu_busy, cpu_done, cpu_rdata, cpu_err, mdio_wr, mdio_data_wr
    );

    modport master (
        output cpu_req, cpu_cmd, mdio_data_rd,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_err, mdio_wr, mdio_data_wr
    );
endinterface

// File: rtl/ctrl_mdio_sched.sv
// Shares one MDIO master between CPU one-shot accesses and a periodic status poller.
// Optional irq/irq_clr ports are built only when CTRL_MDIO_SCHED_IRQ_EN is defined.
module ctrl_mdio_sched #(
    parameter logic [4:0]  POLL_PHY    = 5'd0,
    parameter logic [4:0]  POLL_REG    = 5'd1,
    parameter logic [23:0] POLL_PERIOD = 24'd1000000,
    parameter logic [19:0] TIMEOUT     = 20'd65535
) (
    input  logic                   rst,
    input  logic                   up_clk,
    ctrl_mdio_sched_if.slave       bus,
    input  logic                   poll_en,
    output logic [15:0]            poll_status,
    output logic                   poll_valid,
    output logic                   link_up,
    output logic                   link_chg
`ifdef CTRL_MDIO_SCHED_IRQ_EN
    ,
    output logic                   irq,
    input  logic                   irq_clr
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        COMPLETE
    } state_t;

    localparam logic        OWN_CPU  = 1'b0;
    localparam logic        OWN_POLL = 1'b1;
    localparam logic [31:0] POLL_CMD = {2'b10, 1'b0, POLL_PHY, 3'b000, POLL_REG, 16'h0000};

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] cpu_cmd_q, cpu_cmd_d;
    logic        cpu_pend_q, cpu_pend_d;
    logic        poll_pend_q, poll_pend_d;
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic        cpu_busy_q, cpu_busy_d;
    logic        cpu_done_q, cpu_done_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_err_q, cpu_err_d;
    logic [15:0] poll_status_q, poll_status_d;
    logic        poll_valid_q, poll_valid_d;
    logic        link_chg_q, link_chg_d;
    logic [31:0] mdio_data_wr_q, mdio_data_wr_d;

    logic        poll_wrap;
    logic        poll_clr;
    logic        fin;
    logic        fin_err;
    logic [15:0] fin_data;
    logic        rd_done;
    logic        timeout_hit;
    logic        unused_rd;

    assign rd_done   = bus.mdio_data_rd[29];
    assign unused_rd = ^{bus.mdio_data_rd[31:30], bus.mdio_data_rd[28:16]};

    // ISSUE and the edge into COMPLETE account for two of the TIMEOUT cycles,
    // so COMPLETE lands exactly TIMEOUT cycles after the ISSUE cycle.
    assign timeout_hit = (to_cnt_q >= (TIMEOUT - 20'd2));

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        cpu_cmd_d      = cpu_cmd_q;
        cpu_pend_d     = cpu_pend_q;
        poll_cnt_d     = poll_cnt_q;
        to_cnt_d       = to_cnt_q;
        cpu_busy_d     = cpu_busy_q;
        cpu_done_d     = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_err_d      = cpu_err_q;
        poll_status_d  = poll_status_q;
        poll_valid_d   = poll_valid_q;
        link_chg_d     = 1'b0;
        mdio_data_wr_d = mdio_data_wr_q;
        poll_wrap      = 1'b0;
        poll_clr       = 1'b0;
        fin            = 1'b0;
        fin_err        = 1'b0;
        fin_data       = 16'h0000;

        if (bus.cpu_req && !cpu_busy_q) begin
            cpu_cmd_d  = bus.cpu_cmd;
            cpu_pend_d = 1'b1;
            cpu_busy_d = 1'b1;
        end

        if (!poll_en) begin
            poll_cnt_d = 24'd0;
        end else if (poll_cnt_q == (POLL_PERIOD - 24'd1)) begin
            poll_cnt_d = 24'd0;
            poll_wrap  = 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q + 24'd1;
        end

        case (state_q)
            IDLE: begin
                if (cpu_pend_q) begin
                    owner_d        = OWN_CPU;
                    mdio_data_wr_d = cpu_cmd_q;
                    state_d        = ISSUE;
                end else if (poll_pend_q) begin
                    owner_d        = OWN_POLL;
                    mdio_data_wr_d = POLL_CMD;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = 20'd0;
                if (owner_q == OWN_CPU) begin
                    cpu_pend_d = 1'b0;
                end else begin
                    poll_clr = 1'b1;
                end
                state_d = WAIT_START;
            end
            WAIT_START: begin
                to_cnt_d = to_cnt_q + 20'd1;
                // The master's done flag is stale while idle; only trust it after a low.
                if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (!rd_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                to_cnt_d = to_cnt_q + 20'd1;
                if (rd_done) begin
                    fin      = 1'b1;
                    fin_data = bus.mdio_data_rd[15:0];
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results are registered on the edge into COMPLETE so they are visible during it.
        if (fin) begin
            state_d = COMPLETE;
            if (owner_q == OWN_CPU) begin
                cpu_done_d = 1'b1;
                cpu_busy_d = 1'b0;
                cpu_err_d  = fin_err;
                if (mdio_data_wr_q[31:30] == 2'b10) begin
                    cpu_rdata_d = fin_data;
                end
            end else if (!fin_err) begin
                poll_status_d = fin_data;
                poll_valid_d  = 1'b1;
                link_chg_d    = fin_data[2] ^ poll_status_q[2];
            end
        end

        // A wrap in the same cycle as the poll's ISSUE starts a fresh period.
        poll_pend_d = poll_en ? ((poll_pend_q & ~poll_clr) | poll_wrap) : 1'b0;
    end

    always_ff @(posedge up_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_CPU;
            cpu_cmd_q      <= 32'h0;
            cpu_pend_q     <= 1'b0;
            poll_pend_q    <= 1'b0;
            poll_cnt_q     <= 24'd0;
            to_cnt_q       <= 20'd0;
            cpu_busy_q     <= 1'b0;
            cpu_done_q     <= 1'b0;
            cpu_rdata_q    <= 16'h0;
            cpu_err_q      <= 1'b0;
            poll_status_q  <= 16'h0;
            poll_valid_q   <= 1'b0;
            link_chg_q     <= 1'b0;
            mdio_data_wr_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            cpu_cmd_q      <= cpu_cmd_d;
            cpu_pend_q     <= cpu_pend_d;
            poll_pend_q    <= poll_pend_d;
            poll_cnt_q     <= poll_cnt_d;
            to_cnt_q       <= to_cnt_d;
            cpu_busy_q     <= cpu_busy_d;
            cpu_done_q     <= cpu_done_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_err_q      <= cpu_err_d;
            poll_status_q  <= poll_status_d;
            poll_valid_q   <= poll_valid_d;
            link_chg_q     <= link_chg_d;
            mdio_data_wr_q <= mdio_data_wr_d;
        end
    end

`ifdef CTRL_MDIO_SCHED_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (link_chg_d || (cpu_done_d && cpu_err_d)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge up_clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign bus.mdio_wr      = (state_q == ISSUE);
    assign bus.mdio_data_wr = mdio_data_wr_q;
    assign bus.cpu_busy     = cpu_busy_q;
    assign bus.cpu_done     = cpu_done_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_err      = cpu_err_q;
    assign poll_status      = poll_status_q;
    assign poll_valid       = poll_valid_q;
    assign link_up          = poll_status_q[2];
    assign link_chg         = link_chg_q;

endmodule

// File: tb/tb_ctrl_mdio_sched.sv
// Scoreboard bench for ctrl_mdio_sched: directed CPU/poll scenarios against a simple MDIO master model.
// Expectations are queued by the stimulus and popped by a negedge monitor.
module tb_ctrl_mdio_sched;

    localparam logic [31:0] POLL_CMD = 32'h8001_0000;

    logic up_clk = 1'b0;
    logic rst    = 1'b1;
    always #5 up_clk = ~up_clk;

    ctrl_mdio_sched_if bus ();

    logic        poll_en;
    logic [15:0] poll_status;
    logic        poll_valid;
    logic        link_up;
    logic        link_chg;
`ifdef CTRL_MDIO_SCHED_IRQ_EN
    logic        irq;
    logic        irq_clr = 1'b0;
`endif

    ctrl_mdio_sched #(
        .POLL_PHY    (5'd0),
        .POLL_REG    (5'd1),
        .POLL_PERIOD (24'd100),
        .TIMEOUT     (20'd200)
    ) dut (
        .rst         (rst),
        .up_clk      (up_clk),
        .bus         (bus),
        .poll_en     (poll_en),
        .poll_status (poll_status),
        .poll_valid  (poll_valid),
        .link_up     (link_up),
        .link_chg    (link_chg)
`ifdef CTRL_MDIO_SCHED_IRQ_EN
        ,
        .irq         (irq),
        .irq_clr     (irq_clr)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge up_clk) cyc <= cyc + 1;

    // MDIO master model: done idles high, drops after a write strobe, rises busy_len cycles later.
    logic        m_done  = 1'b1;
    logic [15:0] m_data  = 16'h0;
    int          m_cnt   = 0;
    bit          m_hang  = 1'b0;
    int          m_busy_len = 5;
    logic [15:0] m_rdata = 16'h0;

    assign bus.mdio_data_rd = {2'b00, m_done, 13'h0, m_data};

    always @(negedge up_clk) begin
        if (bus.mdio_wr && !m_hang) begin
            m_done <= 1'b0;
            m_cnt  <= m_busy_len;
        end else if (!m_done) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_data <= m_rdata;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [31:0] cmd;
        int          gap;
    } wr_exp_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } done_exp_t;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    logic      link_q[$];

    int  last_wr_cyc   = 0;
    int  last_done_cyc = 0;
    int  last_poll_cyc = -1;
    int  link_chg_cnt  = 0;
    bit  poll_track    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    wr_exp_t   mon_w;
    done_exp_t mon_d;
    logic      mon_l;

    always @(negedge up_clk) begin
        if (!rst && bus.mdio_wr) begin
            last_wr_cyc = cyc;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mdio_wr: got %h expected no strobe", bus.mdio_data_wr);
            end else begin
                mon_w = wr_q.pop_front();
                chk("mdio_data_wr", bus.mdio_data_wr, mon_w.cmd);
                if (mon_w.gap > 0) chk("issue_after_complete", cyc - last_done_cyc, mon_w.gap);
            end
            if (poll_track && bus.mdio_data_wr == POLL_CMD) begin
                if (last_poll_cyc >= 0) chk("poll_period", cyc - last_poll_cyc, 100);
                last_poll_cyc = cyc;
            end
        end
        if (!rst && bus.cpu_done) begin
            last_done_cyc = cyc;
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cpu_done: got 1 expected 0");
            end else begin
                mon_d = done_q.pop_front();
                chk("cpu_rdata", bus.cpu_rdata, mon_d.rdata);
                chk("cpu_err", bus.cpu_err, mon_d.err);
                chk("cpu_busy_at_done", bus.cpu_busy, 0);
                if (mon_d.lat > 0) chk("issue_to_done", cyc - last_wr_cyc, mon_d.lat);
            end
        end
        if (!rst && link_chg) begin
            link_chg_cnt++;
            if (link_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_link_chg: got link_up %b expected no pulse", link_up);
            end else begin
                mon_l = link_q.pop_front();
                chk("link_up_at_chg", link_up, mon_l);
                chk("poll_status_bit2", poll_status[2], mon_l);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpu_busy"}, bus.cpu_busy, 0);
        chk({tag, "_cpu_done"}, bus.cpu_done, 0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, "_cpu_err"}, bus.cpu_err, 0);
        chk({tag, "_poll_status"}, poll_status, 0);
        chk({tag, "_poll_valid"}, poll_valid, 0);
        chk({tag, "_link_up"}, link_up, 0);
        chk({tag, "_link_chg"}, link_chg, 0);
        chk({tag, "_mdio_wr"}, bus.mdio_wr, 0);
        chk({tag, "_mdio_data_wr"}, bus.mdio_data_wr, 0);
    endtask

    task automatic cpu_issue(input logic [31:0] cmd);
        @(posedge up_clk);
        #1 bus.cpu_req = 1'b1;
        bus.cpu_cmd = cmd;
        @(posedge up_clk);
        #1 bus.cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        int i;
        i = 0;
        while (!bus.cpu_done && i < lim) begin
            @(negedge up_clk);
            i++;
        end
        chk({name, "_done_seen"}, bus.cpu_done, 1);
        @(negedge up_clk);
    endtask

    task automatic push_wr(input logic [31:0] cmd, input int gap);
        wr_exp_t e;
        e.cmd = cmd;
        e.gap = gap;
        wr_q.push_back(e);
    endtask

    task automatic push_done(input logic [15:0] rdata, input logic err, input int lat);
        done_exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        done_q.push_back(e);
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_cmd = 32'h0;
        poll_en     = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge up_clk);
        check_all_zero("reset");
        @(posedge up_clk);
        #1 rst = 1'b0;

        // 1: CPU read with a long busy phase
        m_busy_len = 40;
        m_rdata    = 16'h796D;
        push_wr(32'h8101_0000, 0);
        push_done(16'h796D, 1'b0, 0);
        cpu_issue(32'h8101_0000);
        wait_done("read1", 200);

        // 2: CPU write leaves cpu_rdata untouched even though the master returns data
        m_busy_len = 5;
        m_rdata    = 16'hFFFF;
        push_wr(32'h4100_1140, 0);
        push_done(16'h796D, 1'b0, 0);
        cpu_issue(32'h4100_1140);
        wait_done("write1", 200);
        chk("cpu_busy_after_write", bus.cpu_busy, 0);

        // 3: three polls, link goes up then down
        m_rdata = 16'h0004;
        repeat (3) push_wr(POLL_CMD, 0);
        link_q.push_back(1'b1);
        link_q.push_back(1'b0);
        last_poll_cyc = -1;
        poll_track    = 1'b1;
        @(posedge up_clk);
        #1 poll_en = 1'b1;
        repeat (150) @(posedge up_clk);
        #1 m_rdata = 16'h0000;
        repeat (200) @(posedge up_clk);
        #1 poll_en = 1'b0;
        poll_track = 1'b0;
        repeat (20) @(negedge up_clk);
        chk("poll_valid", poll_valid, 1);
        chk("poll_status_after_polls", poll_status, 16'h0000);
        chk("link_up_after_polls", link_up, 0);
        chk("link_chg_count", link_chg_cnt, 2);
        chk("poll_wr_all_seen", wr_q.size(), 0);

        // 4: CPU and poll pending together; CPU first, poll right after COMPLETE
        m_rdata = 16'hABC8;
        push_wr(32'h8104_0000, 0);
        push_wr(POLL_CMD, 2);
        push_done(16'hABC8, 1'b0, 0);
        @(posedge up_clk);
        #1 poll_en = 1'b1;
        repeat (99) @(posedge up_clk);
        #1 bus.cpu_req = 1'b1;
        bus.cpu_cmd = 32'h8104_0000;
        @(posedge up_clk);
        #1 bus.cpu_req = 1'b0;
        repeat (3) @(posedge up_clk);
        #1 bus.cpu_req = 1'b1;
        bus.cpu_cmd = 32'h4105_0000;
        @(posedge up_clk);
        #1 bus.cpu_req = 1'b0;
        wait_done("arb", 200);
        repeat (30) @(posedge up_clk);
        #1 poll_en = 1'b0;
        repeat (5) @(negedge up_clk);
        chk("poll_status_arb", poll_status, 16'hABC8);
        chk("link_chg_count_arb", link_chg_cnt, 2);
        chk("arb_wr_all_seen", wr_q.size(), 0);

        // 5: master never leaves done=1 -> timeout, then a normal write
        m_hang = 1'b1;
        push_wr(32'h8102_0000, 0);
        push_done(16'h0000, 1'b1, 200);
        cpu_issue(32'h8102_0000);
        wait_done("timeout", 400);
        m_hang = 1'b0;
        push_wr(32'h4102_0000, 0);
        push_done(16'h0000, 1'b0, 0);
        cpu_issue(32'h4102_0000);
        wait_done("after_timeout", 200);

        // 6: reset during WAIT_DONE, then a fresh read
        m_busy_len = 40;
        m_rdata    = 16'h1111;
        push_wr(32'h8103_0000, 0);
        cpu_issue(32'h8103_0000);
        repeat (15) @(posedge up_clk);
        #1 rst = 1'b1;
        @(negedge up_clk);
        check_all_zero("midreset");
        repeat (2) @(posedge up_clk);
        #1 rst = 1'b0;
        repeat (50) @(posedge up_clk);
        m_busy_len = 5;
        m_rdata    = 16'h5555;
        push_wr(32'h8101_0000, 0);
        push_done(16'h5555, 1'b0, 0);
        cpu_issue(32'h8101_0000);
        wait_done("post_reset", 200);

        repeat (5) @(negedge up_clk);
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        chk("link_queue_empty", link_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ctrl_mdio_sched.md
Name: ctrl_mdio_sched

Overview:
- Scheduler in front of the MDIO master (ctrl_mdio); runs in the up_clk domain.
- Shares the single MDIO master between two requesters:
  - the CPU register port, for one-shot PHY reads and writes;
  - an autonomous poller that periodically reads one PHY status register and caches it.
- Sequences each MDIO transaction: issue, start/done detection, timeout, result return.

Parameters:
- POLL_PHY, 5'd0, PHY address used by the poller.
- POLL_REG, 5'd1, register address used by the poller (default is basic status).
- POLL_PERIOD, 24'd1000000, up_clk cycles between poll launches; minimum 16.
- TIMEOUT, 20'd65535, maximum up_clk cycles from issue to completion.

Ports:
- rst  in  1  asynchronous reset, active-high
- up_clk  in  1  single clock for all logic
- cpu_req  in  1  one-cycle request strobe; sampled only while cpu_busy=0
- cpu_cmd  in  32  command word {RW[31:30],1'b0,PHY[28:24],3'b000,REG[20:16],DATA[15:0]}; RW=01 write, RW=10 read
- cpu_busy  out  1  CPU request accepted and not yet completed
- cpu_done  out  1  one-cycle pulse at CPU completion
- cpu_rdata  out  16  read data of the last CPU read; holds its value until the next CPU completion
- cpu_err  out  1  timeout flag for the last CPU transaction; updated at every cpu_done
- poll_en  in  1  enables periodic polling
- poll_status  out  16  last successfully polled register value
- poll_valid  out  1  set on the first successful poll; cleared by reset only
- link_up  out  1  equals poll_status[2]
- link_chg  out  1  one-cycle pulse when link_up changes value
- mdio_wr  out  1  one-cycle write strobe to the MDIO master
- mdio_data_wr  out  32  command word presented to the MDIO master
- mdio_data_rd  in  32  MDIO master readback; bit29 is the done flag, [15:0] is the data

Behaviour:
- Reset values:
  - all outputs 0; mdio_data_wr=0;
  - state=IDLE; poll counter=0; cpu_pend=0; poll_pend=0.
- CPU capture: cpu_req while cpu_busy=0 latches cpu_cmd, sets cpu_pend and sets cpu_busy on the next edge. cpu_req while cpu_busy=1 is ignored.
- Poll timer:
  - while poll_en=1, the counter increments each cycle;
  - at POLL_PERIOD-1 it wraps to 0 and sets poll_pend;
  - poll_pend already set stays set, so a missed period is not queued twice;
  - poll_en=0 clears the counter and poll_pend; an in-flight poll still completes.
- States:
  - IDLE:
    - cpu_pend -> ISSUE with owner=CPU;
    - else poll_pend -> ISSUE with owner=POLL and command {2'b10,1'b0,POLL_PHY,3'b000,POLL_REG,16'h0000};
    - CPU wins when both are pending in the same cycle.
  - ISSUE:
    - drives mdio_wr=1 for exactly one cycle with mdio_data_wr=command;
    - clears the owner's pend flag and the timeout counter;
    - -> WAIT_START.
  - WAIT_START:
    - waits for mdio_data_rd[29]=0; the master reports done=1 stale while idle, so the done flag is qualified only after it has been seen low;
    - -> WAIT_DONE.
  - WAIT_DONE:
    - waits for mdio_data_rd[29]=1;
    - captures mdio_data_rd[15:0] -> COMPLETE with err=0.
  - Timeout: the counter increments in WAIT_START and WAIT_DONE; on reaching TIMEOUT -> COMPLETE with err=1 and data 16'h0000.
  - COMPLETE (1 cycle):
    - owner=CPU: cpu_done=1; cpu_busy=0; cpu_err=err; cpu_rdata=data for reads, unchanged for writes.
    - owner=POLL, err=0: poll_status=data; poll_valid=1; link_chg=1 if the new bit2 differs from the previous link_up.
    - owner=POLL, err=1: poll_status retained; no link_chg.
    - -> IDLE.
- Minimum latency: cpu_req to mdio_wr is 3 cycles (capture, IDLE, ISSUE) when idle.
- mdio_data_wr holds its value after ISSUE until the next ISSUE.
- Reset mid-transaction returns to IDLE immediately. The external master may still finish its frame; the result is discarded.

Optional Feature:
- Macro: CTRL_MDIO_SCHED_IRQ_EN.
- Defined: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is set on link_chg or on a CPU timeout;
  - irq is cleared by irq_clr;
  - a set event in the same cycle as irq_clr wins.
- Undefined: those ports and their logic are absent; everything else is identical.

Test Plan:
1. CPU read, cmd=32'h8101_0000 (PHY1, REG1), model returns 16'h796D with done low for 40 cycles -> exactly one mdio_wr with mdio_data_wr=32'h8101_0000; cpu_done once; cpu_rdata=16'h796D; cpu_err=0.
2. CPU write, cmd=32'h4100_1140 -> mdio_wr with that word; cpu_done; cpu_rdata unchanged; cpu_busy=0 after done.
3. poll_en=1, POLL_PERIOD=100, status 16'h0004 then 16'h0000 -> poll_valid=1; link_up=1 then 0; exactly two link_chg pulses; one poll every 100 cycles.
4. cpu_req and poll_pend in the same IDLE cycle -> CPU command issued first, poll issued right after COMPLETE; a second cpu_req while busy is ignored (single mdio_wr per accepted request).
5. Model holds bit29=1 forever with TIMEOUT=200 -> cpu_done at issue+200; cpu_err=1; cpu_rdata=16'h0000; scheduler accepts the next request.
6. Assert rst during WAIT_DONE -> all outputs 0 next edge; a new cpu_req after reset completes normally.
